// File: rtl/core_types_pkg.sv
// Shared core types: ALU and divider operation encodings plus divider special-case constants.
package core_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Encoding matches funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] DIV_OVF_REM   = 32'h0000_0000;
  localparam logic [31:0] DIV_INT_MIN   = 32'h8000_0000;

  function automatic logic div_is_rem(input div_op_t op);
    return op[1];
  endfunction

  function automatic logic div_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (one quotient bit per cycle) for the M-extension
// divide group, with single-cycle handling of divide-by-zero and signed overflow.
module div_unit
  import core_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  div_op_t     op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] dq_q, dq_d;
  logic [31:0] dsr_q, dsr_d;
  div_op_t     op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        accept;
  logic        in_signed;
  logic        s1_neg, s2_neg;
  logic [31:0] abs1, abs2;
  logic        spec_zero, spec_ovf;
  logic [31:0] spec_result;

  logic [33:0] rem_shift;
  logic [33:0] rem_diff;
  logic        step_ok;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_final, rem_final;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

  assign accept    = in_valid & in_ready & ~flush;
  assign in_signed = div_is_signed(op);
  assign s1_neg    = in_signed & rs1[31];
  assign s2_neg    = in_signed & rs2[31];
  assign abs1      = s1_neg ? (32'd0 - rs1) : rs1;
  assign abs2      = s2_neg ? (32'd0 - rs2) : rs2;

  assign spec_zero = (rs2 == 32'd0);
  assign spec_ovf  = in_signed & (rs1 == DIV_INT_MIN) & (rs2 == 32'hFFFF_FFFF);

  always_comb begin
    spec_result = div_is_rem(op) ? DIV_OVF_REM : DIV_OVF_QUOT;
    if (spec_zero) begin
      spec_result = div_is_rem(op) ? rs1 : DIV_ZERO_QUOT;
    end
  end

  // Restoring step: dq_q shifts the dividend out at the top and the quotient in at the bottom.
  assign rem_shift = {rem_q, dq_q[31]};
  assign rem_diff  = rem_shift - {2'b00, dsr_q};
  assign step_ok   = ~rem_diff[33];
  assign rem_step  = step_ok ? rem_diff[32:0] : rem_shift[32:0];
  assign quo_step  = {dq_q[30:0], step_ok};

  assign quo_final = qneg_q ? (32'd0 - quo_step) : quo_step;
  assign rem_final = rneg_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    dq_d     = dq_q;
    dsr_d    = dsr_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d   = op;
            qneg_d = s1_neg ^ s2_neg;
            rneg_d = s1_neg;
            dq_d   = abs1;
            dsr_d  = abs2;
            rem_d  = 33'd0;
            cnt_d  = 6'd0;
            if (spec_zero || spec_ovf) begin
              result_d = spec_result;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = rem_step;
          dq_d  = quo_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = div_is_rem(op_q) ? rem_final : quo_final;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operand/datapath registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dq_q   <= dq_d;
    dsr_q  <= dsr_d;
    op_q   <= op_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  execute stage presents a divide request.
REQ-004 in_ready  output  1  unit can accept a request; high only in state IDLE.
REQ-005 op  input  div_op_t (2)  DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11; maps to funct3[1:0] of the M-extension divide group.
REQ-006 rs1  input  32  dividend.
REQ-007 rs2  input  32  divisor.
REQ-008 flush  input  1  pipeline kill; abandons any in-flight operation.
REQ-009 out_valid  output  1  result is valid; high only in state DONE.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  32  quotient or remainder, selected per the latched op.

Function
REQ-012 A request SHALL be accepted on an edge where in_valid & in_ready & !flush; op, rs1 and rs2 are latched there, and later input changes are ignored.
REQ-013 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE->CALC on accept of a normal case.
- IDLE->DONE on accept of a special case (REQ-017, REQ-018).
- CALC->DONE after the 32nd iteration.
- DONE->IDLE on out_ready.
REQ-014 On accept, the unit SHALL latch sign flags and absolute operand values for DIV/REM, raw values for DIVU/REMU, and clear the 6-bit iteration counter and the partial remainder.
REQ-015 CALC SHALL perform one restoring-division step per cycle, MSB first, producing one quotient bit per cycle. The counter counts 0..31, and CALC exits on the edge where the counter equals 31.
REQ-016 On entry to DONE, result SHALL be registered as follows:
- DIV/DIVU: the quotient, negated if the operand signs differ (signed ops only).
- REM/REMU: the remainder, taking the dividend's sign (signed ops only).
REQ-017 Divisor == 0 SHALL skip CALC. Result: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = rs1.
REQ-018 Signed overflow (DIV/REM with rs1=32'h8000_0000, rs2=32'hFFFF_FFFF) SHALL skip CALC. Result: DIV = 32'h8000_0000; REM = 0.
REQ-019 Latency SHALL be as follows, with no bypass of the result register:
- Normal case: out_valid asserts 33 cycles after the accept edge.
- Special case: out_valid asserts 1 cycle after the accept edge.
REQ-020 out_valid and result SHALL hold stable in DONE until out_ready is sampled high; the DONE->IDLE edge deasserts out_valid.
REQ-021 in_ready SHALL be low in CALC and DONE, so back-to-back accept is impossible.
REQ-022 flush SHALL force IDLE on the next edge from any state and deassert out_valid there. flush has priority over both accept and out_ready.
REQ-023 All arithmetic SHALL be 32-bit two's complement. The partial remainder SHALL be 33 bits so that the subtract borrow is visible.

Reset
REQ-024 rst_n low SHALL asynchronously force:
- state = IDLE and the counter to 0.
- result = 0, out_valid = 0, in_ready = 1 (as a function of IDLE).
REQ-025 Reset asserted mid-CALC SHALL discard the operation; no out_valid follows deassertion.

Structure
REQ-026 div_op_t and the special-case result constants SHALL live in core_types_pkg beside alu_op_t; the FSM state enum stays local to the module.
REQ-027 No sub-module; the single-step subtract/shift SHALL be inline combinational logic in div_unit.

Verification
REQ-028 DIVU rs1=100, rs2=7 -> out_valid 33 cycles after accept, result=14; then REMU on the same operands -> result=2.
REQ-029 DIV rs1=-100, rs2=7 -> result=-14 (32'hFFFF_FFF2); REM on the same operands -> result=-2 (32'hFFFF_FFFE).
REQ-030 DIV rs2=0, rs1=5 -> out_valid 1 cycle after accept, result=32'hFFFF_FFFF; REM -> result=5.
REQ-031 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> result=32'h8000_0000 after 1 cycle; REM -> result=0.
REQ-032 flush at CALC counter=10 -> IDLE next cycle, in_ready=1, no out_valid; flush concurrent with in_valid in IDLE -> no accept.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; rst_n pulse mid-CALC -> all outputs at reset values, no spurious out_valid.
